// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a W x H raster of unsigned N-bit activations.
// Optional frame_done output is enabled by defining MAXPOOL_FRAME_DONE_EN.
module maxpool2x2_stream #(
   parameter int unsigned N = 14,
   parameter int unsigned W = 26,
   parameter int unsigned H = 26
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic [N-1:0] din,
   input  logic         din_valid,
   output logic [N-1:0] dout,
   output logic         dout_valid
`ifdef MAXPOOL_FRAME_DONE_EN
   ,
   output logic         frame_done
`endif
);

   localparam int unsigned CW = $clog2(W);
   localparam int unsigned RW = $clog2(H);
   localparam int unsigned LW = (CW > 1) ? CW - 1 : 1;
   localparam int unsigned LD = 1 << LW;

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [N-1:0]  r_hhold;
   logic [N-1:0]  r_dout;
   logic          r_dout_valid;
   logic [N-1:0]  r_lb [LD];
`ifdef MAXPOOL_FRAME_DONE_EN
   logic          r_frame_done;
`endif

   logic          w_col_last;
   logic          w_row_last;
   logic [LW-1:0] w_lb_idx;
   logic [N-1:0]  w_hmax;
   logic [N-1:0]  w_lb_rd;
   logic [N-1:0]  w_vmax;
   logic          w_lb_we;

   always_comb begin
      w_col_last = (r_col == CW'(W - 1));
      w_row_last = (r_row == RW'(H - 1));
      w_lb_idx   = LW'(r_col >> 1);
      w_hmax     = (din > r_hhold) ? din : r_hhold;
      w_lb_rd    = r_lb[w_lb_idx];
      w_vmax     = (w_hmax > w_lb_rd) ? w_hmax : w_lb_rd;
      // Even rows park horizontal maxima; the following odd row consumes them.
      w_lb_we    = din_valid & ~flush & r_col[0] & ~r_row[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col        <= '0;
         r_row        <= '0;
         r_hhold      <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
`ifdef MAXPOOL_FRAME_DONE_EN
         r_frame_done <= 1'b0;
`endif
      end else if (flush) begin
         r_col        <= '0;
         r_row        <= '0;
         r_hhold      <= '0;
         r_dout_valid <= 1'b0;
`ifdef MAXPOOL_FRAME_DONE_EN
         r_frame_done <= 1'b0;
`endif
      end else begin
         r_dout_valid <= 1'b0;
`ifdef MAXPOOL_FRAME_DONE_EN
         r_frame_done <= 1'b0;
`endif
         if (din_valid) begin
            if (!r_col[0]) begin
               r_hhold <= din;
            end
            if (r_col[0] && r_row[0]) begin
               r_dout       <= w_vmax;
               r_dout_valid <= 1'b1;
`ifdef MAXPOOL_FRAME_DONE_EN
               r_frame_done <= w_col_last & w_row_last;
`endif
            end
            if (w_col_last) begin
               r_col <= '0;
               r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
               r_col <= r_col + CW'(1);
            end
         end
      end
   end

   // Line buffer carries no reset; every entry is written before it is read.
   always_ff @(posedge clk) begin
      if (w_lb_we) begin
         r_lb[w_lb_idx] <= w_hmax;
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
`ifdef MAXPOOL_FRAME_DONE_EN
   assign frame_done = r_frame_done;
`endif

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: a frame-array reference model queues expected
// windows while a negedge monitor checks every output cycle.
module tb_maxpool2x2_stream;

   localparam int unsigned N = 14;
   localparam int unsigned W = 4;
   localparam int unsigned H = 4;
   localparam int unsigned NPIX = W * H;
   localparam logic [N-1:0] MAXV = '1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic [N-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic [N-1:0] dout;
   logic         dout_valid;
`ifdef MAXPOOL_FRAME_DONE_EN
   logic         frame_done;
`endif

   maxpool2x2_stream #(.N(N), .W(W), .H(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid)
`ifdef MAXPOOL_FRAME_DONE_EN
      ,
      .frame_done (frame_done)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int n_out  = 0;

   typedef struct {
      logic [N-1:0] v;
      int           due;
      bit           fd;
   } exp_t;

   exp_t         q[$];
   exp_t         e;
   logic [N-1:0] img [H][W];
   int           p = 0;
   logic [N-1:0] last_exp = '0;
   bit           prev_v = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: store the raster into a frame array; each bottom-right pixel of a
   // 2x2 window yields the max of that window, due on the edge that accepted it.
   task automatic model_accept(input logic [N-1:0] d);
      int r, c;
      logic [N-1:0] m;
      r = p / W;
      c = p % W;
      img[r][c] = d;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
         m = img[r-1][c-1];
         if (img[r-1][c] > m) m = img[r-1][c];
         if (img[r][c-1] > m) m = img[r][c-1];
         if (img[r][c] > m) m = img[r][c];
         q.push_back('{v: m, due: cyc, fd: (r == H - 1) && (c == W - 1)});
      end
      p = (p + 1) % NPIX;
   endtask

   task automatic drive(input bit v, input logic [N-1:0] d, input bit fl);
      din_valid = v;
      din       = d;
      flush     = fl;
      @(posedge clk);
      #1;
      if (fl) p = 0;
      else if (v) model_accept(d);
      din_valid = 1'b0;
      flush     = 1'b0;
      din       = N'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, N'($urandom), 1'b0);
   endtask

   task automatic send_frame(input logic [N-1:0] f [NPIX], input bit gaps);
      for (int i = 0; i < NPIX; i++) begin
         drive(1'b1, f[i], 1'b0);
         if (gaps) drive(1'b0, N'($urandom), 1'b0);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         check("reset_dout", int'(dout), 0);
         check("reset_dout_valid", int'(dout_valid), 0);
`ifdef MAXPOOL_FRAME_DONE_EN
         check("reset_frame_done", int'(frame_done), 0);
`endif
         last_exp = '0;
         prev_v   = 1'b0;
      end else begin
         while (q.size() > 0 && q[0].due < cyc) begin
            check("missing_output_due_cycle", cyc, q[0].due);
            void'(q.pop_front());
         end
         if (dout_valid) begin
            n_out++;
            check("dout_valid_back_to_back", int'(prev_v), 0);
            if (q.size() == 0) begin
               check("unexpected_output", int'(dout_valid), 0);
            end else begin
               e = q.pop_front();
               check("dout_value", int'(dout), int'(e.v));
               check("dout_latency", cyc, e.due);
`ifdef MAXPOOL_FRAME_DONE_EN
               check("frame_done_on_output", int'(frame_done), int'(e.fd));
`endif
               last_exp = e.v;
            end
         end else begin
            check("dout_hold", int'(dout), int'(last_exp));
`ifdef MAXPOOL_FRAME_DONE_EN
            check("frame_done_idle", int'(frame_done), 0);
`endif
         end
         prev_v = dout_valid;
      end
   end

   logic [N-1:0] basic [NPIX];
   logic [N-1:0] fmax  [NPIX];
   logic [N-1:0] fzero [NPIX];
   logic [N-1:0] frnd  [NPIX];
   int           n0;

   initial begin
      basic = '{1, 5, 2, 3, 4, 0, 7, 6, 9, 9, 0, 0, 9, 8, 0, 1};
      for (int i = 0; i < NPIX; i++) begin
         fmax[i]  = MAXV;
         fzero[i] = '0;
      end
      fmax[5] = '0;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Basic frame, continuous valid.
      n0 = n_out;
      send_frame(basic, 1'b0);
      idle(3);
      check("basic_output_count", n_out - n0, 4);
      check("basic_last_dout", int'(dout), 1);

      // Asynchronous reset mid-frame after 3 pixels.
      for (int i = 0; i < 3; i++) drive(1'b1, basic[i] + N'(1), 1'b0);
      #1 rst = 1'b1;
      #1;
      check("async_reset_dout", int'(dout), 0);
      check("async_reset_dout_valid", int'(dout_valid), 0);
      p = 0;
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      n0 = n_out;
      send_frame(basic, 1'b0);
      idle(3);
      check("post_reset_output_count", n_out - n0, 4);

      // Same frame with alternating valid gaps.
      n0 = n_out;
      send_frame(basic, 1'b1);
      idle(2);
      check("gap_output_count", n_out - n0, 4);

      // Max-value frame immediately followed by all-zero frame.
      n0 = n_out;
      send_frame(fmax, 1'b0);
      send_frame(fzero, 1'b0);
      idle(3);
      check("back_to_back_output_count", n_out - n0, 8);

      // Flush at row 1, col 2 with din_valid high, then a clean frame.
      n0 = n_out;
      for (int i = 0; i < W + 2; i++) drive(1'b1, MAXV - N'(i), 1'b0);
      drive(1'b1, MAXV, 1'b1);
      idle(2);
      check("flush_partial_output_count", n_out - n0, 1);
      n0 = n_out;
      send_frame(basic, 1'b0);
      idle(3);
      check("post_flush_output_count", n_out - n0, 4);

      // Random frames with random gaps, extreme values and occasional flushes.
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < NPIX; i++) begin
            case ($urandom_range(0, 5))
               0:       frnd[i] = '0;
               1:       frnd[i] = MAXV;
               default: frnd[i] = N'($urandom);
            endcase
         end
         for (int i = 0; i < NPIX; i++) begin
            while ($urandom_range(0, 3) == 0) drive(1'b0, N'($urandom), 1'b0);
            if ($urandom_range(0, 60) == 0) drive($urandom_range(0, 1) == 1, frnd[i], 1'b1);
            drive(1'b1, frnd[i], 1'b0);
         end
      end
      idle(4);
      check("scoreboard_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/maxpool2x2_stream.md
# maxpool2x2_stream

- Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the ReLU activation in the CNN datapath.
- Consumes one activation per valid cycle in row-major raster order and keeps half a line of horizontal partial maxima.
- Emits one registered pooled value per 2×2 window, reducing a W×H feature map to (W/2)×(H/2).

## Interface
Parameters:
- N, 14, data width; matches the ReLU output width.
- W, 26, feature-map width in pixels; even, ≥2.
- H, 26, feature-map height in rows; even, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous; abandons the current frame and returns to row 0, col 0.
- din  input  N  activation from ReLU; unsigned, since ReLU output is non-negative.
- din_valid  input  1  din is valid this cycle.
- dout  output  N  pooled maximum.
- dout_valid  output  1  dout is valid; single-cycle pulse per window.
- frame_done  output  1  present only with MAXPOOL_FRAME_DONE_EN; see Configuration.

## Operation
- Counters:
  - col runs 0..W-1 and row runs 0..H-1.
  - Both advance only on cycles with din_valid=1.
  - col wraps to 0 at W-1, and row increments on that wrap.
  - row wraps to 0 at H-1 with col=W-1, starting a new frame with no idle cycle required.
- Horizontal stage:
  - Even col: hold din in register h_hold.
  - Odd col: hmax = max(h_hold, din), unsigned compare.
  - Ties select either value (the values are equal).
- Even row, odd col: write hmax to line buffer lb[col>>1]. The buffer has W/2 entries of N bits. No output.
- Odd row, odd col:
  - dout <= max(lb[col>>1], hmax).
  - dout_valid <= 1 on the next clock edge.
- All other accepted cycles, and cycles with din_valid=0: dout_valid <= 0. dout holds its last value.
- Gaps in din_valid are allowed anywhere, including mid-pair. State is held across gaps.
- Line buffer entries are written before they are read within each row pair. Stale data from a previous pair is never read.
- Width rules:
  - Comparisons are unsigned over N bits; no widening or truncation.
  - col uses $clog2(W) bits and row uses $clog2(H) bits.
- flush:
  - Effect on the next edge: col=0, row=0, h_hold=0, dout_valid=0.
  - The line buffer is not cleared.
  - flush has priority over din_valid in the same cycle; that pixel is discarded.
- Reset (rst=1, asynchronous):
  - dout=0, dout_valid=0, frame_done=0, col=0, row=0, h_hold=0.
  - Line buffer contents are don't-care.
  - Reset mid-frame discards the partial frame. The first valid pixel after reset release is row 0, col 0.

## Timing
- Latency: dout_valid rises on the clock edge after the cycle accepting the bottom-right pixel of a window (1 cycle).
- Throughput: one input per cycle sustained.
  - Full-rate outputs are 1 per 2 cycles during odd rows and none during even rows.
- dout_valid is never high for two consecutive cycles.
- Line buffer:
  - May be distributed registers or a synchronous-write RAM.
  - Read is combinational or pre-fetched; the 1-cycle latency above is fixed either way.
- No backpressure: the downstream stage must accept dout whenever dout_valid=1.

## Configuration
- MAXPOOL_FRAME_DONE_EN defined:
  - frame_done port exists.
  - frame_done pulses 1 for exactly one cycle, coincident with the dout_valid of the final window (row H-1, col W-1).
  - It is 0 at reset and cleared by flush.
- Not defined:
  - frame_done port and its logic are absent.
  - All other behaviour is identical.

## Test plan
Test configuration: W=4, H=4, N=14.
- Reset values: assert rst mid-stream after 3 pixels → dout=0 and dout_valid=0 immediately, without waiting for a clock edge. After release, a full frame produces exactly 4 outputs.
- Basic frame: continuous valid input.
  - Rows: [1,5,2,3], [4,0,7,6], [9,9,0,0], [9,8,0,1].
  - Required outputs: dout=5 and 7 one cycle after row-1 col-1 and col-3; dout=9 and 1 after row-3 col-1 and col-3.
  - dout_valid is high on exactly 4 cycles.
- Valid gaps: same frame with din_valid toggling 1,0,1,0… → identical 4 values in order, each 1 cycle after its last pixel.
- Boundary values and back-to-back frames:
  - Frame of all 16383 (max N-bit) with one 0 → every output is 16383.
  - Immediately following frame of all 0 → four outputs of 0.
  - No idle cycle between the two frames.
- flush: assert flush with din_valid=1 at row 1, col 2, then send a full clean frame → no spurious output from the abandoned frame; the clean frame's 4 results are correct.
- frame_done (MAXPOOL_FRAME_DONE_EN): frame_done is high only on the cycle dout=1 is emitted in the basic frame. It is also low after a flush-aborted frame.
